// File: rtl/vector_sequencer.sv
// Pops {last, cycles, data} vectors and drives each on the selected mosi lane for cycles+1 clocks, writing sampled miso to the result FIFO.
// Optional build macro VEC_SEQ_STATS_EN adds saturating vec_count / stall_count outputs.
module vector_sequencer #(
    parameter int STF_WIDTH   = 24,
    parameter int RTF_WIDTH   = 24,
    parameter int CYCLE_RANGE = 5,
    parameter int NUM_TARGETS = 4,
    parameter int DSEL_WIDTH  = 5
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               start,
    input  logic                               capture_all,
    input  logic [DSEL_WIDTH-1:0]              target_sel,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    input  logic [STF_WIDTH+CYCLE_RANGE:0]     sfifo_data,
    output logic                               sfifo_rdreq,
    input  logic                               sfifo_rdempty,
    output logic [RTF_WIDTH-1:0]               rfifo_data,
    output logic                               rfifo_wrreq,
    input  logic                               rfifo_wrfull,
    output logic [NUM_TARGETS*STF_WIDTH-1:0]   mosi,
    input  logic [NUM_TARGETS*RTF_WIDTH-1:0]   miso
`ifdef VEC_SEQ_STATS_EN
    ,
    output logic [15:0]                        vec_count,
    output logic [15:0]                        stall_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, APPLY, DONE} state_t;

    localparam logic [DSEL_WIDTH:0] NUM_TGT = (DSEL_WIDTH+1)'(NUM_TARGETS);

    state_t                 state_q, state_d;
    logic [DSEL_WIDTH-1:0]  sel_q, sel_d;
    logic                   mode_q, mode_d;
    logic                   last_q, last_d;
    logic                   error_q, error_d;
    logic                   wrreq_q, wrreq_d;
    logic [STF_WIDTH-1:0]   vec_q, vec_d;
    logic [CYCLE_RANGE-1:0] cnt_q, cnt_d;
    logic [RTF_WIDTH-1:0]   rdata_q, rdata_d;
    logic [RTF_WIDTH-1:0]   miso_sel;
    logic                   cap_pt;

    always_comb begin
        miso_sel = '0;
        for (int k = 0; k < NUM_TARGETS; k++)
            if (sel_q == DSEL_WIDTH'(k)) miso_sel = miso[k*RTF_WIDTH +: RTF_WIDTH];
    end

    // The lane keeps showing the last vector while FETCH waits for the next one.
    always_comb begin
        mosi = '0;
        if (state_q == FETCH || state_q == APPLY)
            for (int k = 0; k < NUM_TARGETS; k++)
                if (sel_q == DSEL_WIDTH'(k)) mosi[k*STF_WIDTH +: STF_WIDTH] = vec_q;
    end

    assign cap_pt      = mode_q | (cnt_q == '0);
    assign busy        = (state_q == FETCH) || (state_q == APPLY);
    assign done        = (state_q == DONE);
    assign error       = error_q;
    assign rfifo_data  = rdata_q;
    assign rfifo_wrreq = wrreq_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mode_d      = mode_q;
        last_d      = last_q;
        error_d     = error_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        wrreq_d     = 1'b0;
        sfifo_rdreq = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sel_d   = target_sel;
                    mode_d  = capture_all;
                    vec_d   = '0;
                    error_d = ({1'b0, target_sel} >= NUM_TGT);
                    state_d = ({1'b0, target_sel} >= NUM_TGT) ? DONE : FETCH;
                end
                FETCH: if (!sfifo_rdempty) begin
                    sfifo_rdreq = 1'b1;
                    vec_d       = sfifo_data[STF_WIDTH-1:0];
                    cnt_d       = sfifo_data[STF_WIDTH +: CYCLE_RANGE];
                    last_d      = sfifo_data[STF_WIDTH+CYCLE_RANGE];
                    state_d     = APPLY;
                end
                APPLY: begin
                    if (!cap_pt) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!rfifo_wrfull) begin
                        wrreq_d = 1'b1;
                        rdata_d = miso_sel;
                        if (cnt_q == '0) state_d = last_q ? DONE : FETCH;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
            wrreq_q <= 1'b0;
            vec_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            error_q <= error_d;
            wrreq_q <= wrreq_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef VEC_SEQ_STATS_EN
    logic [15:0] vcnt_q, scnt_q;
    logic        start_ok, stall_cyc, retire;

    assign start_ok  = enable && (state_q == IDLE) && start;
    assign stall_cyc = enable && (state_q == APPLY) && cap_pt && rfifo_wrfull;
    assign retire    = enable && (state_q == APPLY) && (cnt_q == '0) && !rfifo_wrfull;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vcnt_q <= '0;
            scnt_q <= '0;
        end else if (start_ok) begin
            vcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (retire && vcnt_q != 16'hFFFF)    vcnt_q <= vcnt_q + 16'd1;
            if (stall_cyc && scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
        end
    end

    assign vec_count   = vcnt_q;
    assign stall_count = scnt_q;
`endif

endmodule
